// File: rtl/mdu_issue_ctrl.sv
// MDU issue control: start pulse, occupancy counter and ID stall.
// Long ops hold the unit for a fixed number of cycles.
module mdu_issue_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_mduop,
  input  logic        e_flush,
  input  logic [31:0] e_a,
  input  logic [31:0] e_b,
  input  logic [3:0]  id_mduop,
  output logic        mdu_start,
  output logic [3:0]  mdu_op,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  output logic        stall,
  output logic        busy,
  output logic [1:0]  state,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t     st;
  logic [3:0] cnt;
  logic       perr;

  logic e_legal;
  logic e_long;
  logic e_bad;
  logic id_legal;
  logic accept;
  logic go_mul;
  logic go_div;

  assign e_legal  = (e_mduop != 4'd0) && (e_mduop <= 4'd8);
  assign e_long   = (e_mduop != 4'd0) && (e_mduop <= 4'd4);
  assign e_bad    = e_mduop >= 4'd9;
  assign id_legal = (id_mduop != 4'd0) && (id_mduop <= 4'd8);

  assign busy   = cnt != 4'd0;
  assign accept = e_valid & e_legal & ~e_flush & ~busy;
  assign go_mul = accept & e_long & (e_mduop <= 4'd2);
  assign go_div = accept & e_long & (e_mduop >= 4'd3);

  assign mdu_start = accept;
  assign mdu_op    = accept ? e_mduop : 4'd0;
  assign mdu_a     = accept ? e_a : 32'd0;
  assign mdu_b     = accept ? e_b : 32'd0;

  // Hold ID only for MDU ops; other instructions flow past a busy unit.
  assign stall = id_legal & (busy | (accept & e_long));

  assign state     = st;
  assign proto_err = perr;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= 4'd0;
      st   <= IDLE;
      perr <= 1'b0;
    end else begin
      // An op arriving while busy means the ID stall was bypassed.
      if ((e_valid & e_legal & busy) | (e_valid & e_bad))
        perr <= 1'b1;
      unique case (1'b1)
        go_mul: begin
          cnt <= 4'(MULT_CYCLES);
          st  <= MUL;
        end
        go_div: begin
          cnt <= 4'(DIV_CYCLES);
          st  <= DIV;
        end
        busy: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            st <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule
